// File: rtl/hexfp_pkg.sv
// Shared definitions for the 32-bit hex-float datapath: field positions,
// exponent constants, special encodings, FSM states and digit-count helper.
package hexfp_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_W    = 7;
  localparam int QUOT_W   = 28;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 24;
  localparam int MANT_MSB = 23;
  localparam int MANT_LSB = 0;

  localparam logic signed [9:0] BIAS    = 10'sd64;
  localparam logic signed [9:0] EXP_MAX = 10'sd127;

  localparam logic [31:0] HEXFP_ZERO   = 32'h0000_0000;
  localparam logic [30:0] HEXFP_MAXMAG = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, PREP, DIVIDE, PACK} state_t;

  // Leading zero hex digits of a fraction, saturating at 5 (zero fraction also gives 5).
  function automatic logic [2:0] lead_hex_zeros(input logic [MANT_W-1:0] m);
    logic [2:0] k;
    k = 3'd5;
    for (int i = 1; i <= 5; i++) begin
      if (m[4*i +: 4] != 4'h0) begin
        k = 3'(5 - i);
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/hexfp_divider_if.sv
// Start/done handshake bundle for the hex-float divider.
interface hexfp_divider_if;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;
  logic        exp_ovf;
  logic        exp_unf;

  modport master (
    output start, dataa, datab,
    input  busy, done, result, div_by_zero, exp_ovf, exp_unf
  );

  modport slave (
    input  start, dataa, datab,
    output busy, done, result, div_by_zero, exp_ovf, exp_unf
  );
endinterface

// File: rtl/hexfp_normalize.sv
// Combinational hex-digit normaliser: shifts leading zero digits out of the
// fraction and lowers the exponent to match, widening it to signed 9 bits.
module hexfp_normalize
  import hexfp_pkg::*;
(
  input  logic [EXP_W-1:0]        exp_i,
  input  logic [MANT_W-1:0]       mant_i,
  output logic [MANT_W-1:0]       mant_o,
  output logic signed [EXP_W+1:0] exp_o
);

  logic [2:0] k_s;

  // Count, shift and adjust in one step.
  always_comb begin
    k_s    = lead_hex_zeros(mant_i);
    mant_o = mant_i << {k_s, 2'b00};
    exp_o  = $signed({2'b00, exp_i}) - $signed({6'b000000, k_s});
  end

endmodule

// File: rtl/hexfp_divider.sv
// Sequential hex-float divider: one cycle of normalisation, 28 restoring
// division steps, one packing cycle; quotient truncated, done pulses once.
module hexfp_divider
  import hexfp_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  hexfp_divider_if.slave bus
);

  state_t                  state_q, state_d;
  logic [31:0]             a_q, a_d, b_q, b_d;
  logic [MANT_W-1:0]       ma_q, ma_d, mb_q, mb_d;
  logic signed [EXP_W+1:0] ea_q, ea_d, eb_q, eb_d;
  logic                    sign_q, sign_d;
  logic [QUOT_W-1:0]       rem_q, rem_d, quo_q, quo_d, cnt_q, cnt_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [31:0]             result_q, result_d;
  logic                    dbz_q, dbz_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [MANT_W-1:0]       na_mant_s, nb_mant_s, mant_s;
  logic signed [EXP_W+1:0] na_exp_s, nb_exp_s;
  logic                    borrow_s, hi_s;
  logic [QUOT_W-1:0]       diff_s;
  logic signed [9:0]       e_s;

  hexfp_normalize u_norm_a (
    .exp_i  (a_q[EXP_MSB:EXP_LSB]),
    .mant_i (a_q[MANT_MSB:MANT_LSB]),
    .mant_o (na_mant_s),
    .exp_o  (na_exp_s)
  );

  hexfp_normalize u_norm_b (
    .exp_i  (b_q[EXP_MSB:EXP_LSB]),
    .mant_i (b_q[MANT_MSB:MANT_LSB]),
    .mant_o (nb_mant_s),
    .exp_o  (nb_exp_s)
  );

  // Next-state, datapath and output computation for every state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    sign_d   = sign_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    // Divisor is pre-scaled by 8 so the first step yields quotient bit 27.
    {borrow_s, diff_s} = {1'b0, rem_q} - {2'b00, mb_q, 3'b000};
    hi_s   = (quo_q[27:24] != 4'h0);
    mant_s = hi_s ? quo_q[27:4] : quo_q[23:0];
    e_s    = $signed({ea_q[EXP_W+1], ea_q}) - $signed({eb_q[EXP_W+1], eb_q})
             + BIAS + (hi_s ? 10'sd1 : 10'sd0);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.dataa;
          b_d     = bus.datab;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = PREP;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        ma_d    = na_mant_s;
        mb_d    = nb_mant_s;
        ea_d    = na_exp_s;
        eb_d    = nb_exp_s;
        sign_d  = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
        rem_d   = {4'h0, na_mant_s};
        quo_d   = {QUOT_W{1'b0}};
        cnt_d   = {1'b1, {(QUOT_W-1){1'b0}}};
        state_d = DIVIDE;
      end
      DIVIDE: begin
        if (!borrow_s) begin
          rem_d = diff_s << 1;
          quo_d = {quo_q[QUOT_W-2:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          quo_d = {quo_q[QUOT_W-2:0], 1'b0};
        end
        cnt_d = cnt_q >> 1;
        if (cnt_q[0]) begin
          state_d = PACK;
        end else begin
          state_d = DIVIDE;
        end
      end
      PACK: begin
        if (mb_q == {MANT_W{1'b0}}) begin
          result_d = {sign_q, HEXFP_MAXMAG};
          dbz_d    = 1'b1;
        end else if (ma_q == {MANT_W{1'b0}}) begin
          result_d = HEXFP_ZERO;
        end else if (e_s > EXP_MAX) begin
          result_d = {sign_q, HEXFP_MAXMAG};
          ovf_d    = 1'b1;
        end else if (e_s < 10'sd0) begin
          result_d = HEXFP_ZERO;
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, e_s[6:0], mant_s};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
      ma_q     <= {MANT_W{1'b0}};
      mb_q     <= {MANT_W{1'b0}};
      ea_q     <= 9'sd0;
      eb_q     <= 9'sd0;
      sign_q   <= 1'b0;
      rem_q    <= {QUOT_W{1'b0}};
      quo_q    <= {QUOT_W{1'b0}};
      cnt_q    <= {QUOT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= HEXFP_ZERO;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      sign_q   <= sign_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.exp_ovf     = ovf_q;
  assign bus.exp_unf     = unf_q;

endmodule

// File: tb/tb_hexfp_divider.sv
// Scoreboard bench for hexfp_divider: directed operand pairs push expected
// quotient, flags and completion cycle; a monitor checks each done pulse.
module tb_hexfp_divider;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  hexfp_divider_if dut_if ();

  hexfp_divider dut (
    .clock (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && dut_if.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result %h with no request outstanding", dut_if.result);
        end else begin
          e = sb.pop_front();
          check("result", dut_if.result, e.res);
          check("flags", {29'd0, dut_if.div_by_zero, dut_if.exp_ovf, dut_if.exp_unf}, {29'd0, e.flg});
          check("latency", cyc, e.due);
        end
      end
    end
  end

  // Issue one request at the current negedge, optionally re-pulse start mid-operation,
  // and return at the negedge where done is seen (so the next call is back-to-back).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [2:0] flg, input int poke);
    exp_t e;
    int   n;
    dut_if.start = 1'b1;
    dut_if.dataa = a;
    dut_if.datab = b;
    e.res = res;
    e.flg = flg;
    e.due = cyc + 31;
    sb.push_back(e);
    @(negedge clk);
    dut_if.start = 1'b0;
    check("busy_after_accept", {31'd0, dut_if.busy}, 32'd1);
    n = 1;
    while (!dut_if.done && n < 40) begin
      if (n == poke) begin
        dut_if.start = 1'b1;
        dut_if.dataa = 32'h7F10_0000;
        dut_if.datab = 32'h0010_0000;
      end else begin
        dut_if.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    dut_if.start = 1'b0;
    if (!dut_if.done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for %h / %h within 40 cycles", a, b);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    reset        = 1'b1;
    dut_if.start = 1'b0;
    dut_if.dataa = 32'h0;
    dut_if.datab = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, dut_if.busy}, 32'd0);
    check("reset_done", {31'd0, dut_if.done}, 32'd0);
    check("reset_result", dut_if.result, 32'h0);
    check("reset_flags", {29'd0, dut_if.div_by_zero, dut_if.exp_ovf, dut_if.exp_unf}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'h4110_0000, 32'h4110_0000, 32'h4110_0000, 3'b000, 0);
    run_op(32'h4110_0000, 32'h4120_0000, 32'h4080_0000, 3'b000, 0);
    run_op(32'h4110_0000, 32'h4130_0000, 32'h4055_5555, 3'b000, 0);
    run_op(32'hC160_0000, 32'h4120_0000, 32'hC130_0000, 3'b000, 0);
    run_op(32'h4110_0000, 32'hC120_0000, 32'hC080_0000, 3'b000, 0);
    run_op(32'h4201_0000, 32'h4110_0000, 32'h4110_0000, 3'b000, 0);
    run_op(32'h4600_0001, 32'h4110_0000, 32'h4110_0000, 3'b000, 0);
    run_op(32'h4110_0000, 32'h4201_0000, 32'h4110_0000, 3'b000, 0);
    run_op(32'h4110_0000, 32'h0000_0000, 32'h7FFF_FFFF, 3'b100, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 3'b100, 0);
    run_op(32'h0000_0000, 32'h4110_0000, 32'h0000_0000, 3'b000, 0);
    run_op(32'h8000_0000, 32'hC110_0000, 32'h0000_0000, 3'b000, 0);
    run_op(32'h0010_0000, 32'h7F10_0000, 32'h0000_0000, 3'b001, 0);
    run_op(32'h0010_0000, 32'h4120_0000, 32'h0000_0000, 3'b001, 0);
    run_op(32'h0020_0000, 32'h4110_0000, 32'h0020_0000, 3'b000, 0);
    run_op(32'h7F20_0000, 32'h4120_0000, 32'h7F10_0000, 3'b000, 0);
    run_op(32'h7F10_0000, 32'h0010_0000, 32'h7FFF_FFFF, 3'b010, 0);
    run_op(32'hFF10_0000, 32'h0010_0000, 32'hFFFF_FFFF, 3'b010, 0);
    // A second start mid-operation must be ignored.
    run_op(32'h4110_0000, 32'h4120_0000, 32'h4080_0000, 3'b000, 10);

    // Reset in the middle of an operation: aborted, no done afterwards.
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.dataa = 32'h4110_0000;
    dut_if.datab = 32'h4130_0000;
    @(negedge clk);
    dut_if.start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, dut_if.busy}, 32'd0);
    check("abort_done", {31'd0, dut_if.done}, 32'd0);
    check("abort_result", dut_if.result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (35) @(negedge clk);
    run_op(32'hC160_0000, 32'h4120_0000, 32'hC130_0000, 3'b000, 0);
    repeat (4) @(negedge clk);
    check("flags_hold", {29'd0, dut_if.div_by_zero, dut_if.exp_ovf, dut_if.exp_unf}, 32'd0);
    check("result_hold", dut_if.result, 32'hC130_0000);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
